// File: rtl/layer_error_monitor_if.sv
// Stream bundle between the forward-pass / dataset producers and the
// layer error monitor. The master side drives tokens, words and targets
// and consumes the epoch-error result. The slave side is the monitor.
interface layer_error_monitor_if #(
   parameter int NEURON_NUM          = 4,
   parameter int NEURON_OUTPUT_WIDTH = 12,
   parameter int ACTIVATION_WIDTH    = 9,
   parameter int LAYER_ADDR_WIDTH    = 2,
   parameter int DATASET_ADDR_WIDTH  = 10,
   parameter int ACC_WIDTH           = 32
) ();

   logic [LAYER_ADDR_WIDTH-1:0]                layer;
   logic                                       layer_valid;
   logic                                       layer_ready;

   logic [NEURON_NUM*NEURON_OUTPUT_WIDTH-1:0]  outputs;
   logic                                       outputs_valid;
   logic                                       outputs_ready;

   logic [NEURON_NUM*ACTIVATION_WIDTH-1:0]     targets;
   logic                                       targets_valid;
   logic                                       targets_ready;

   logic [ACC_WIDTH-1:0]                       epoch_error;
   logic                                       epoch_error_valid;
   logic                                       epoch_error_ready;

   logic                                       saturated;
   logic [DATASET_ADDR_WIDTH-1:0]              sample_count;
   logic                                       busy;

   modport master (
      output layer, layer_valid,
      input  layer_ready,
      output outputs, outputs_valid,
      input  outputs_ready,
      output targets, targets_valid,
      input  targets_ready,
      input  epoch_error, epoch_error_valid,
      output epoch_error_ready,
      input  saturated, sample_count, busy
   );

   modport slave (
      input  layer, layer_valid,
      output layer_ready,
      input  outputs, outputs_valid,
      output outputs_ready,
      input  targets, targets_valid,
      output targets_ready,
      output epoch_error, epoch_error_valid,
      input  epoch_error_ready,
      output saturated, sample_count, busy
   );

endinterface

// File: rtl/layer_error_monitor.sv
// Layer error monitor: consumes one forward output word per layer token,
// drops hidden-layer words, and for the top layer accumulates the summed
// absolute error against the sample target (one neuron per cycle). After
// MAX_SAMPLES top-layer samples the clamped epoch sum is emitted.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | waiting for a layer token (layer_ready=1)
//   DROP  | hidden layer: swallow one outputs word, targets untouched
//   LOAD  | top layer: wait for outputs and targets, consume both at once
//   ACC   | add |out[i]-tgt[i]| for i = 0..NEURON_NUM-1, one per cycle
//   EMIT  | epoch result valid, all input readies low until accepted
module layer_error_monitor #(
   parameter int NEURON_NUM          = 4,
   parameter int NEURON_OUTPUT_WIDTH = 12,
   parameter int ACTIVATION_WIDTH    = 9,
   parameter int LAYER_ADDR_WIDTH    = 2,
   parameter int LAYER_MAX           = 2,
   parameter int DATASET_ADDR_WIDTH  = 10,
   parameter int MAX_SAMPLES         = 1000,
   parameter int ACC_WIDTH           = 32
) (
   input logic                  clk,
   input logic                  rst,
   layer_error_monitor_if.slave mon
);

   localparam int OUT_W  = NEURON_NUM * NEURON_OUTPUT_WIDTH;
   localparam int TGT_W  = NEURON_NUM * ACTIVATION_WIDTH;
   // One extra bit holds out - tgt for every operand combination.
   localparam int DIFF_W = NEURON_OUTPUT_WIDTH + 1;
   localparam int IDX_W  = (NEURON_NUM > 1) ? $clog2(NEURON_NUM) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DROP,
      ST_LOAD,
      ST_ACC,
      ST_EMIT
   } state_t;

   state_t                          state_q;
   logic [OUT_W-1:0]                out_q;
   logic [TGT_W-1:0]                tgt_q;
   logic [IDX_W-1:0]                idx_q;
   logic [ACC_WIDTH-1:0]            acc_q;
   logic                            sat_q;
   logic [DATASET_ADDR_WIDTH-1:0]   cnt_q;
   logic [ACC_WIDTH-1:0]            err_q;
   logic                            err_valid_q;
   logic                            sat_out_q;

   logic                            join_ok;
   logic                            last_neuron;
   logic signed [NEURON_OUTPUT_WIDTH-1:0] out_sl;
   logic signed [ACTIVATION_WIDTH-1:0]    tgt_sl;
   logic signed [DIFF_W-1:0]        diff;
   logic [DIFF_W-1:0]               abs_diff;
   logic [ACC_WIDTH:0]              sum_wide;
   logic [ACC_WIDTH-1:0]            acc_d;
   logic                            sat_d;
   logic [DATASET_ADDR_WIDTH-1:0]   cnt_d;

   // Both top-layer words must be present before either is taken.
   assign join_ok = mon.outputs_valid && mon.targets_valid;

   assign mon.layer_ready       = (state_q == ST_IDLE);
   assign mon.outputs_ready     = (state_q == ST_DROP) ||
                                  ((state_q == ST_LOAD) && join_ok);
   assign mon.targets_ready     = (state_q == ST_LOAD) && join_ok;
   assign mon.epoch_error       = err_q;
   assign mon.epoch_error_valid = err_valid_q;
   assign mon.saturated         = sat_out_q;
   assign mon.sample_count      = cnt_q;
   assign mon.busy              = (state_q != ST_IDLE);

   assign last_neuron = (idx_q == IDX_W'(NEURON_NUM - 1));
   assign cnt_d       = cnt_q + 1'b1;

   // Per-neuron absolute difference and clamped accumulator update.
   always_comb begin
      out_sl   = out_q[int'(idx_q) * NEURON_OUTPUT_WIDTH +: NEURON_OUTPUT_WIDTH];
      tgt_sl   = tgt_q[int'(idx_q) * ACTIVATION_WIDTH +: ACTIVATION_WIDTH];
      diff     = $signed({out_sl[NEURON_OUTPUT_WIDTH-1], out_sl})
               - $signed({{(DIFF_W - ACTIVATION_WIDTH){tgt_sl[ACTIVATION_WIDTH-1]}}, tgt_sl});
      abs_diff = diff[DIFF_W-1] ? $unsigned(-diff) : $unsigned(diff);
      sum_wide = {1'b0, acc_q} + (ACC_WIDTH + 1)'(abs_diff);
      acc_d    = sum_wide[ACC_WIDTH-1:0];
      sat_d    = sat_q;
      if (sum_wide[ACC_WIDTH]) begin
         acc_d = '1;
         sat_d = 1'b1;
      end
   end

   // Sequencing FSM with registered epoch result and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         out_q       <= '0;
         tgt_q       <= '0;
         idx_q       <= '0;
         acc_q       <= '0;
         sat_q       <= 1'b0;
         cnt_q       <= '0;
         err_q       <= '0;
         err_valid_q <= 1'b0;
         sat_out_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (mon.layer_valid) begin
                  if (mon.layer == LAYER_ADDR_WIDTH'(LAYER_MAX)) begin
                     state_q <= ST_LOAD;
                  end else begin
                     state_q <= ST_DROP;
                  end
               end
            end
            ST_DROP: begin
               if (mon.outputs_valid) begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LOAD: begin
               if (join_ok) begin
                  out_q   <= mon.outputs;
                  tgt_q   <= mon.targets;
                  idx_q   <= '0;
                  state_q <= ST_ACC;
               end
            end
            ST_ACC: begin
               acc_q <= acc_d;
               sat_q <= sat_d;
               if (last_neuron) begin
                  cnt_q <= cnt_d;
                  if (cnt_d == DATASET_ADDR_WIDTH'(MAX_SAMPLES)) begin
                     err_q       <= acc_d;
                     sat_out_q   <= sat_d;
                     err_valid_q <= 1'b1;
                     state_q     <= ST_EMIT;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  idx_q <= idx_q + 1'b1;
               end
            end
            ST_EMIT: begin
               if (mon.epoch_error_ready) begin
                  acc_q       <= '0;
                  sat_q       <= 1'b0;
                  cnt_q       <= '0;
                  err_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer_error_monitor.sv
// Bench for layer_error_monitor: table of layer/output/target records with
// hand-computed per-sample error sums feeding an epoch model and a result
// scoreboard, plus directed sequences for join stall, EMIT backpressure and
// a mid-epoch reset. Small epoch (4 samples) and a 12-bit accumulator.
module tb_layer_error_monitor;

   localparam int NN    = 4;
   localparam int OW    = 12;
   localparam int AW    = 9;
   localparam int LW    = 2;
   localparam int LMAX  = 2;
   localparam int DW    = 10;
   localparam int NSAMP = 4;
   localparam int ACCW  = 12;
   localparam int ACC_MAX = 4095;
   localparam int TMO   = 50;

   logic clk;
   logic rst;

   layer_error_monitor_if #(
      .NEURON_NUM(NN), .NEURON_OUTPUT_WIDTH(OW), .ACTIVATION_WIDTH(AW),
      .LAYER_ADDR_WIDTH(LW), .DATASET_ADDR_WIDTH(DW), .ACC_WIDTH(ACCW)
   ) mon ();

   layer_error_monitor #(
      .NEURON_NUM(NN), .NEURON_OUTPUT_WIDTH(OW), .ACTIVATION_WIDTH(AW),
      .LAYER_ADDR_WIDTH(LW), .LAYER_MAX(LMAX), .DATASET_ADDR_WIDTH(DW),
      .MAX_SAMPLES(NSAMP), .ACC_WIDTH(ACCW)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mon (mon)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] layer;
      int         o[4];
      int         t[4];
      int         sum;
   } vec_t;

   typedef struct {
      int err;
      int sat;
   } exp_t;

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   int   m_acc = 0;
   int   m_sat = 0;
   int   m_cnt = 0;

   vec_t tbl[12];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [1:0] l,
                               input int o0, input int o1, input int o2, input int o3,
                               input int t0, input int t1, input int t2, input int t3,
                               input int s);
      vec_t v;
      v.layer = l;
      v.o[0] = o0; v.o[1] = o1; v.o[2] = o2; v.o[3] = o3;
      v.t[0] = t0; v.t[1] = t1; v.t[2] = t2; v.t[3] = t3;
      v.sum = s;
      return v;
   endfunction

   function automatic logic [NN*OW-1:0] pack_out(input vec_t v);
      logic [NN*OW-1:0] w;
      w = '0;
      for (int i = 0; i < NN; i++) w[i*OW +: OW] = OW'(v.o[i]);
      return w;
   endfunction

   function automatic logic [NN*AW-1:0] pack_tgt(input vec_t v);
      logic [NN*AW-1:0] w;
      w = '0;
      for (int i = 0; i < NN; i++) w[i*AW +: AW] = AW'(v.t[i]);
      return w;
   endfunction

   // Epoch model: accumulate the per-sample sum, clip at the 12-bit maximum.
   task automatic model_add(input int sum);
      if (m_acc + sum > ACC_MAX) begin
         m_acc = ACC_MAX;
         m_sat = 1;
      end else begin
         m_acc = m_acc + sum;
      end
      m_cnt++;
      if (m_cnt == NSAMP) begin
         sb.push_back('{err: m_acc, sat: m_sat});
         m_acc = 0;
         m_sat = 0;
         m_cnt = 0;
      end
   endtask

   // Scoreboard pop when the DUT hands off an epoch result.
   always @(negedge clk) begin
      if (!rst && mon.epoch_error_valid && mon.epoch_error_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_emit", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("epoch_error", int'(mon.epoch_error), e.err);
            check("saturated", int'(mon.saturated), e.sat);
         end
      end
   end

   task automatic send_token(input logic [1:0] lay);
      int n;
      @(posedge clk); #1;
      mon.layer = lay;
      mon.layer_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!mon.layer_ready && n < TMO) begin
         @(negedge clk);
         n++;
      end
      check("layer_accept", int'(mon.layer_ready), 1);
      @(posedge clk); #1;
      mon.layer_valid = 1'b0;
   endtask

   // Offers outputs and targets together; returns 1 ns after the consuming edge.
   task automatic send_word(input logic [NN*OW-1:0] ow, input logic [NN*AW-1:0] tw,
                            input bit top);
      int   n;
      logic tr_seen;
      mon.outputs = ow;
      mon.outputs_valid = 1'b1;
      mon.targets = tw;
      mon.targets_valid = 1'b1;
      tr_seen = 1'b0;
      n = 0;
      @(negedge clk);
      while (!mon.outputs_ready && n < TMO) begin
         tr_seen = tr_seen | mon.targets_ready;
         @(negedge clk);
         n++;
      end
      check("outputs_accept", int'(mon.outputs_ready), 1);
      if (top) check("top_targets_ready", int'(mon.targets_ready), 1);
      else     check("hidden_targets_ready", int'(tr_seen | mon.targets_ready), 0);
      @(posedge clk); #1;
      mon.outputs_valid = 1'b0;
      mon.targets_valid = 1'b0;
   endtask

   // Called 1 ns after the LOAD edge: four ACC cycles, count moves on the last.
   task automatic top_done(input int sum);
      int prev;
      prev = m_cnt;
      model_add(sum);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("count_before_acc_end", int'(mon.sample_count), prev);
      check("busy_in_acc", int'(mon.busy), 1);
      @(posedge clk);
      @(negedge clk);
      check("count_after_acc", int'(mon.sample_count), prev + 1);
      check("emit_valid_timing", int'(mon.epoch_error_valid), int'(prev + 1 == NSAMP));
   endtask

   task automatic hidden_done();
      @(negedge clk);
      check("drop_back_idle", int'(mon.busy), 0);
      check("drop_count", int'(mon.sample_count), m_cnt);
   endtask

   task automatic run_vec(input vec_t v);
      bit top;
      top = (v.layer == 2'(LMAX));
      send_token(v.layer);
      send_word(pack_out(v), pack_tgt(v), top);
      if (top) top_done(v.sum);
      else     hidden_done();
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_layer_ready"}, int'(mon.layer_ready), 1);
      check({tag, "_outputs_ready"}, int'(mon.outputs_ready), 0);
      check({tag, "_targets_ready"}, int'(mon.targets_ready), 0);
      check({tag, "_epoch_error"}, int'(mon.epoch_error), 0);
      check({tag, "_epoch_valid"}, int'(mon.epoch_error_valid), 0);
      check({tag, "_saturated"}, int'(mon.saturated), 0);
      check({tag, "_sample_count"}, int'(mon.sample_count), 0);
      check({tag, "_busy"}, int'(mon.busy), 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t js;
      tbl[0]  = mk(2'd0,     5,     6,     7,     8,    1,    2,   3,   4,    0);
      tbl[1]  = mk(2'd2,   100,   -50,     0,   256,   90,  -60,   0, 255,   21);
      tbl[2]  = mk(2'd1,    -1,  2047, -2048,    33,    7,   -7, 100, -90,    0);
      tbl[3]  = mk(2'd2,     0,     0,     0,     0, -256,  255,   1,  -1,  513);
      tbl[4]  = mk(2'd3,   123,  -456,   789, -1011,   11,  -22,  33, -44,    0);
      tbl[5]  = mk(2'd2,  -100,   200,  -300,   400, -100,  100,-200, 100,  500);
      tbl[6]  = mk(2'd2,  1000, -1000,     5,     7,   -1,    1,   5,   7, 2002);
      tbl[7]  = mk(2'd2, -2048, -2048, -2048, -2048,  255,  255, 255, 255, 9212);
      tbl[8]  = mk(2'd2, -2048, -2048, -2048, -2048,  255,  255, 255, 255, 9212);
      tbl[9]  = mk(2'd0,    42,    42,    42,    42,   42,   42,  42,  42,    0);
      tbl[10] = mk(2'd2,   100,   -50,     0,   256,   90,  -60,   0, 255,   21);
      tbl[11] = mk(2'd2,     0,     0,     0,     0, -256,  255,   1,  -1,  513);

      rst = 1'b1;
      mon.layer = '0;
      mon.layer_valid = 1'b0;
      mon.outputs = '0;
      mon.outputs_valid = 1'b0;
      mon.targets = '0;
      mon.targets_valid = 1'b0;
      mon.epoch_error_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Table: hidden drops, epoch 1 (3036, unclipped), epoch 2 (clipped).
      for (int k = 0; k < 12; k++) run_vec(tbl[k]);

      // Join stall: outputs waiting, targets arrive five cycles late.
      js = mk(2'd2, 1, 2, 3, 4, 0, 0, 0, 0, 10);
      send_token(2'd2);
      mon.outputs = pack_out(js);
      mon.outputs_valid = 1'b1;
      mon.targets_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_outputs_ready", int'(mon.outputs_ready), 0);
         check("stall_targets_ready", int'(mon.targets_ready), 0);
         @(posedge clk); #1;
      end
      mon.targets = pack_tgt(js);
      mon.targets_valid = 1'b1;
      @(negedge clk);
      check("join_outputs_ready", int'(mon.outputs_ready), 1);
      check("join_targets_ready", int'(mon.targets_ready), 1);
      @(posedge clk); #1;
      mon.outputs_valid = 1'b0;
      mon.targets_valid = 1'b0;
      top_done(js.sum);

      // EMIT backpressure with a token pending.
      run_vec(tbl[1]);
      run_vec(tbl[1]);
      mon.epoch_error_ready = 1'b0;
      run_vec(tbl[1]);
      @(posedge clk); #1;
      mon.layer = 2'd0;
      mon.layer_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_layer_ready", int'(mon.layer_ready), 0);
         check("bp_valid", int'(mon.epoch_error_valid), 1);
         check("bp_error_stable", int'(mon.epoch_error), 73);
         check("bp_count", int'(mon.sample_count), NSAMP);
         @(posedge clk); #1;
      end
      mon.epoch_error_ready = 1'b1;
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check("post_emit_count", int'(mon.sample_count), 0);
      check("post_emit_valid", int'(mon.epoch_error_valid), 0);
      check("post_emit_layer_ready", int'(mon.layer_ready), 1);
      @(posedge clk);
      @(negedge clk);
      check("pending_token_taken", int'(mon.busy), 1);
      check("pending_drop_ready", int'(mon.outputs_ready), 1);
      @(posedge clk); #1;
      mon.layer_valid = 1'b0;
      mon.outputs_valid = 1'b1;
      @(negedge clk);
      check("pending_drop_consume", int'(mon.outputs_ready), 1);
      @(posedge clk); #1;
      mon.outputs_valid = 1'b0;
      hidden_done();

      // Mid-epoch reset during the ACC of sample 3.
      run_vec(tbl[1]);
      run_vec(tbl[1]);
      send_token(2'd2);
      send_word(pack_out(tbl[1]), pack_tgt(tbl[1]), 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_values("midreset");
      @(posedge clk); #1;
      rst = 1'b0;
      m_acc = 0;
      m_sat = 0;
      m_cnt = 0;
      run_vec(tbl[1]);
      run_vec(tbl[3]);
      run_vec(tbl[5]);
      run_vec(tbl[10]);

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
